// File: rtl/pipe_mem_arbiter_pkg.sv
// pipe_mem_arbiter_pkg: shared owner encoding, default latencies and read tag type
package pipe_mem_arbiter_pkg;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam int RD_LAT_DEF      = 1;
    localparam int MAX_IF_WAIT_DEF = 3;

    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;

endpackage

// File: rtl/pipe_mem_tagq.sv
// pipe_mem_tagq: DEPTH-stage shift pipeline carrying read tags to the return cycle
module pipe_mem_tagq
    import pipe_mem_arbiter_pkg::*;
#(
    parameter int DEPTH = RD_LAT_DEF
) (
    input  logic clock,
    input  logic resetn,
    input  tag_t push_i,
    output tag_t tail_o
);

    tag_t tags_q [DEPTH];

    // shift every cycle; reset drops every in-flight tag
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) tags_q[i] <= '0;
        end else begin
            tags_q[0] <= push_i;
            for (int i = 1; i < DEPTH; i++) tags_q[i] <= tags_q[i-1];
        end
    end

    assign tail_o = tags_q[DEPTH-1];

endmodule

// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: single-port memory arbiter between IF fetch and MEM load/store
module pipe_mem_arbiter
    import pipe_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RD_LAT      = RD_LAT_DEF,
    parameter int MAX_IF_WAIT = MAX_IF_WAIT_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [3:0]        starve_q, starve_d;
    logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
    tag_t              push, tail;

    // grant, memory drive and tag generation; MEM wins unless IF has waited too long
    always_comb begin
        dm_gnt     = resetn & dm_req & ~(if_req & (starve_q == 4'(MAX_IF_WAIT)));
        if_gnt     = resetn & if_req & ~dm_gnt;
        if_stall   = resetn & if_req & ~if_gnt;
        dm_stall   = resetn & dm_req & ~dm_gnt;
        mem_en     = if_gnt | dm_gnt;
        mem_we     = dm_gnt & dm_we;
        mem_addr   = dm_gnt ? dm_addr : (if_gnt ? if_addr : '0);
        mem_wdata  = dm_gnt ? dm_wdata : '0;
        push.valid = if_gnt | (dm_gnt & ~dm_we);
        push.owner = dm_gnt ? OWN_DM : OWN_IF;
        starve_d   = (if_req & ~if_gnt) ?
                     ((starve_q == 4'(MAX_IF_WAIT)) ? starve_q : starve_q + 4'd1) : 4'd0;
    end

    pipe_mem_tagq #(.DEPTH(RD_LAT)) u_tagq (
        .clock  (clock),
        .resetn (resetn),
        .push_i (push),
        .tail_o (tail)
    );

    // returning read steers mem_rdata to its owner; the other side shows its last data
    always_comb begin
        if_valid = tail.valid & (tail.owner == OWN_IF);
        dm_valid = tail.valid & (tail.owner == OWN_DM);
        if_rdata = if_valid ? mem_rdata : if_rdata_q;
        dm_rdata = dm_valid ? mem_rdata : dm_rdata_q;
    end

    // starve counter and held read data
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            starve_q   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata;
            dm_rdata_q <= dm_rdata;
        end
    end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb_pipe_mem_arbiter: directed checks of grant, starvation, tagging and reset behaviour
module tb_pipe_mem_arbiter;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;

    logic        if_gnt1, if_valid1, if_stall1, dm_gnt1, dm_valid1, dm_stall1, mem_en1, mem_we1;
    logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        if_gnt2, if_valid2, if_stall2, dm_gnt2, dm_valid2, dm_stall2, mem_en2, mem_we2;
    logic [31:0] if_rdata2, dm_rdata2, mem_addr2, mem_wdata2, mem_rdata2;

    logic [31:0] mem [256];
    logic [31:0] rd1 = '0, rd2a = '0, rd2b = '0;
    int checks = 0, errors = 0;

    always #5 clock = ~clock;

    pipe_mem_arbiter #(.RD_LAT(1), .MAX_IF_WAIT(3)) u_dut1 (
        .clock(clock), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_valid(if_valid1),
        .if_rdata(if_rdata1), .if_stall(if_stall1),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt1), .dm_valid(dm_valid1), .dm_rdata(dm_rdata1), .dm_stall(dm_stall1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1)
    );

    pipe_mem_arbiter #(.RD_LAT(2), .MAX_IF_WAIT(3)) u_dut2 (
        .clock(clock), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt2), .if_valid(if_valid2),
        .if_rdata(if_rdata2), .if_stall(if_stall2),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt2), .dm_valid(dm_valid2), .dm_rdata(dm_rdata2), .dm_stall(dm_stall2),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2)
    );

    // memory model: 1-cycle read for dut1, 2-cycle read for dut2, writes from dut1
    always @(posedge clock) begin
        rd1  <= mem[mem_addr1[9:2]];
        rd2a <= mem[mem_addr2[9:2]];
        rd2b <= rd2a;
        if (mem_en1 && mem_we1) mem[mem_addr1[9:2]] <= mem_wdata1;
    end
    assign mem_rdata1 = rd1;
    assign mem_rdata2 = rd2b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dw, input logic [31:0] da, input logic [31:0] dd);
        next_cycle();
        if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
        @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'h8C010000;
        mem[8'h00] = 32'h11111111;
        mem[8'h40] = 32'h22222222;
        mem[8'h01] = 32'h33333333;

        // reset with requests pending: everything gated off
        if_req = 1'b1; dm_req = 1'b1;
        @(negedge clock);
        check("rst_if_gnt", 64'(if_gnt1), 64'd0);
        check("rst_dm_gnt", 64'(dm_gnt1), 64'd0);
        check("rst_mem_en", 64'(mem_en1), 64'd0);
        check("rst_if_stall", 64'(if_stall1), 64'd0);
        check("rst_dm_stall", 64'(dm_stall1), 64'd0);
        check("rst_valids", 64'({if_valid1, dm_valid1}), 64'd0);
        check("rst_rdata", 64'({if_rdata1, dm_rdata1}), 64'd0);
        next_cycle();
        resetn = 1'b1; if_req = 1'b0; dm_req = 1'b0;
        @(negedge clock);

        // single IF read
        drive(1, 32'h40, 0, 0, 0, 0);
        check("ifrd_gnt", 64'({if_gnt1, dm_gnt1}), 64'b10);
        check("ifrd_mem", 64'({mem_en1, mem_we1}), 64'b10);
        check("ifrd_addr", 64'(mem_addr1), 64'h40);
        drive(0, 0, 0, 0, 0, 0);
        check("ifrd_valid", 64'({if_valid1, dm_valid1}), 64'b10);
        check("ifrd_data", 64'(if_rdata1), 64'h8C010000);
        drive(0, 0, 0, 0, 0, 0);
        check("ifrd_one_wide", 64'(if_valid1), 64'd0);
        check("ifrd_hold", 64'(if_rdata1), 64'h8C010000);

        // store then load
        drive(0, 0, 1, 1, 32'h80, 32'hDEADBEEF);
        check("st_gnt", 64'(dm_gnt1), 64'd1);
        check("st_mem", 64'({mem_en1, mem_we1}), 64'b11);
        check("st_wdata", 64'(mem_wdata1), 64'hDEADBEEF);
        drive(0, 0, 1, 0, 32'h80, 0);
        check("ld_we", 64'(mem_we1), 64'd0);
        check("st_no_valid", 64'(dm_valid1), 64'd0);
        drive(0, 0, 0, 0, 0, 0);
        check("ld_valid", 64'({if_valid1, dm_valid1}), 64'b01);
        check("ld_data", 64'(dm_rdata1), 64'hDEADBEEF);
        check("ld_if_hold", 64'(if_rdata1), 64'h8C010000);

        // contention: DM,DM,DM,IF,DM,DM
        for (int i = 0; i < 6; i++) begin
            drive(1, 32'h40, 1, 0, 32'h80, 0);
            check($sformatf("cont%0d_dm_gnt", i), 64'(dm_gnt1), 64'(i != 3));
            check($sformatf("cont%0d_if_gnt", i), 64'(if_gnt1), 64'(i == 3));
            check($sformatf("cont%0d_if_stall", i), 64'(if_stall1), 64'(i != 3));
            check($sformatf("cont%0d_dm_stall", i), 64'(dm_stall1), 64'(i == 3));
        end
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0);

        // back-to-back reads on the 2-cycle-latency instance
        drive(1, 32'h0, 0, 0, 0, 0);
        check("b2b_c0_gnt", 64'(if_gnt2), 64'd1);
        drive(0, 0, 1, 0, 32'h100, 0);
        check("b2b_c1_gnt", 64'(dm_gnt2), 64'd1);
        check("b2b_c1_valids", 64'({if_valid2, dm_valid2}), 64'b00);
        drive(1, 32'h4, 0, 0, 0, 0);
        check("b2b_c2_valids", 64'({if_valid2, dm_valid2}), 64'b10);
        check("b2b_c2_data", 64'(if_rdata2), 64'h11111111);
        drive(0, 0, 0, 0, 0, 0);
        check("b2b_c3_valids", 64'({if_valid2, dm_valid2}), 64'b01);
        check("b2b_c3_data", 64'(dm_rdata2), 64'h22222222);
        drive(0, 0, 0, 0, 0, 0);
        check("b2b_c4_valids", 64'({if_valid2, dm_valid2}), 64'b10);
        check("b2b_c4_data", 64'(if_rdata2), 64'h33333333);
        drive(0, 0, 0, 0, 0, 0);
        check("b2b_c5_valids", 64'({if_valid2, dm_valid2}), 64'b00);

        // reset while an IF read is in flight
        drive(1, 32'h40, 1, 0, 32'h80, 0);
        drive(1, 32'h40, 1, 0, 32'h80, 0);
        drive(1, 32'h40, 0, 0, 0, 0);
        check("rmf_gnt", 64'(if_gnt1), 64'd1);
        next_cycle();
        resetn = 1'b0; if_req = 1'b0;
        @(negedge clock);
        check("rmf_valid_in_rst", 64'({if_valid1, dm_valid1}), 64'd0);
        check("rmf_rdata_cleared", 64'(if_rdata1), 64'd0);
        next_cycle();
        resetn = 1'b1;
        @(negedge clock);
        check("rmf_starve", 64'(u_dut1.starve_q), 64'd0);
        check("rmf_valid_after", 64'({if_valid1, dm_valid1}), 64'd0);

        // idle
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            check($sformatf("idle%0d_mem_en", i), 64'({mem_en1, mem_en2}), 64'd0);
            check($sformatf("idle%0d_stalls", i), 64'({if_stall1, dm_stall1}), 64'd0);
            check($sformatf("idle%0d_valids", i), 64'({if_valid1, dm_valid1, if_valid2, dm_valid2}), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_mem_arbiter.md
Name: pipe_mem_arbiter

Overview:
- Arbitrates one single-port unified memory between two requesters: the IF stage (instruction fetch, read-only) and the MEM stage (data load/store).
- Sits between pipeif/pipemem and the shared memory macro.
- Issues at most one access per cycle and tags in-flight reads so each read returns to its owner.
- Drives per-requester stall outputs that the pipeline uses to freeze the PC and the pipeline registers.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RD_LAT, 1, memory read latency in cycles (1..4); reads return exactly RD_LAT cycles after issue.
- MAX_IF_WAIT, 3, consecutive cycles IF may be denied before it is forced to win (1..15).

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- if_req  in  1  IF read request; held until granted.
- if_addr  in  ADDR_W  IF word address.
- if_gnt  out  1  IF granted this cycle (combinational).
- if_valid  out  1  if_rdata valid this cycle.
- if_rdata  out  DATA_W  instruction word.
- if_stall  out  1  IF must hold (if_req & ~if_gnt).
- dm_req  in  1  MEM-stage request; held until granted.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_gnt  out  1  MEM granted this cycle (combinational).
- dm_valid  out  1  dm_rdata valid (loads only).
- dm_rdata  out  DATA_W  load data.
- dm_stall  out  1  MEM must hold (dm_req & ~dm_gnt).
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, RD_LAT cycles after a read strobe.

Behaviour:
- Reset (resetn=0, asynchronous):
  - Starve counter and tag pipeline are cleared.
  - if_valid, dm_valid and the registered rdata outputs read 0.
  - Combinational gnt, stall and mem_* outputs follow the request inputs, gated off while resetn=0: all read 0 during reset.
- Reset mid-operation discards every in-flight read. No valid is ever emitted for an access issued before reset.
- Grant rule, combinational, evaluated every cycle:
  - Only dm_req: dm_gnt=1.
  - Only if_req: if_gnt=1.
  - Both: dm_gnt=1 unless starve_cnt==MAX_IF_WAIT, in which case if_gnt=1.
  - if_gnt and dm_gnt are never both 1.
- Starve counter (4-bit, saturating at MAX_IF_WAIT):
  - Increments when if_req=1 and if_gnt=0.
  - Clears when if_gnt=1 or if_req=0.
- Memory drive:
  - mem_en = if_gnt | dm_gnt.
  - mem_we = dm_gnt & dm_we.
  - mem_addr and mem_wdata are muxed from the granted requester.
  - With no grant, mem_addr and mem_wdata are 0.
- Stores complete in the grant cycle. They produce no dm_valid and no tag.
- Read tagging:
  - A shift pipeline of RD_LAT entries {valid, owner} is loaded at each read grant (owner: 0=IF, 1=MEM).
  - The pipeline shifts every cycle, supporting back-to-back reads.
  - At the tail, if valid: owner=IF asserts if_valid=1 and if_rdata=mem_rdata; owner=MEM asserts dm_valid=1 and dm_rdata=mem_rdata.
  - if_valid and dm_valid are registered, mutually exclusive, and 1 cycle wide.
  - The rdata of the non-owner holds its last value.
- Throughput: one access per cycle. A read issued in cycle t returns valid in cycle t+RD_LAT.
- Simultaneous events: a grant and a return in the same cycle are independent. The new tag enters at the head while the old tag exits at the tail.
- Requests asserted during reset are not granted until resetn=1.

Decomposition:
- Shared package holds:
  - owner encoding constants (OWN_IF=0, OWN_DM=1);
  - the RD_LAT and MAX_IF_WAIT defaults;
  - the tag struct {valid, owner}.
- One natural sub-module: pipe_mem_tagq, the RD_LAT-deep tag shift pipeline with async clear.
- The grant logic and starve counter stay in the top module.

Test Plan:
- Single IF read: if_req=1, if_addr=0x40, memory returns 0x8C010000 → if_gnt=1 in cycle 0; if_valid=1 and if_rdata=0x8C010000 in cycle 1 (RD_LAT=1); dm_valid stays 0.
- Store then load: dm_we=1, dm_addr=0x80, dm_wdata=0xDEADBEEF, then dm_we=0 at 0x80 → store cycle has mem_we=1 and no dm_valid; the load returns dm_rdata=0xDEADBEEF one cycle after its grant.
- Contention: if_req and dm_req held high for 6 cycles, MAX_IF_WAIT=3 → grants DM,DM,DM,IF,DM,DM; if_stall=1 exactly in cycles 0-2 and 4-5.
- Back-to-back reads IF@0x0, DM@0x100, IF@0x4 with RD_LAT=2 → valids arrive in cycles 2, 3, 4, each on the correct owner with the correct data.
- Reset mid-flight: grant an IF read, pull resetn low in the next cycle → if_valid never asserts; the starve counter reads 0 after release.
- Idle: no requests for 10 cycles → mem_en=0, both stalls 0, no valids.
